// File: rtl/extend_pkg.sv
// extend_pkg: shared types for the pipelined immediate-extension stage
package extend_pkg;
  typedef enum logic [2:0] {
    IMM12_Z   = 3'b000,
    MEM_OFS   = 3'b001,
    BRANCH    = 3'b010,
    ROT_IMM   = 3'b011,
    MEM_OFS_S = 3'b100
  } imm_src_t;
  typedef logic [1:0] mem_sel_t;
  localparam mem_sel_t WORD = 2'b00;
  localparam mem_sel_t BYTE = 2'b01;
  localparam mem_sel_t HALF = 2'b10;
  typedef struct packed {
    mem_sel_t mem_sel;
    logic     rot_carry;
    logic     illegal;
  } ext_side_t;
endpackage

// File: rtl/extend_skid_fifo.sv
// extend_skid_fifo: 2-entry valid/ready FIFO whose head register drives the outputs
module extend_skid_fifo #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     din,
  output logic out_valid,
  input  logic out_ready,
  output T     dout
);
  logic [1:0] count_q, count_d;
  T head_q, head_d, tail_q, tail_d;
  logic push, pop;
  assign out_valid = count_q != 2'd0;
  assign dout = head_q;
  always_comb begin
    in_ready = rst_n && (count_q != 2'd2 || out_ready);
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready;
    count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    // head refills from the skid entry when full, else takes the incoming beat once it is the oldest
    head_d = (count_q == 2'd2 && pop) ? tail_q :
             (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) ? din : head_q;
    tail_d = (push && (count_q == 2'd2 || (count_q == 2'd1 && !pop))) ? din : tail_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/extend_pipe.sv
// extend_pipe: pipelined ARM immediate extender with a 2-entry result buffer
module extend_pipe
  import extend_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [2:0]         ImmSrc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ExtImm,
  output logic [1:0]         MemorySelector,
  output logic               RotCarry,
  output logic               Illegal
);
  typedef struct packed {
    logic [DATA_W-1:0] ext_imm;
    ext_side_t         side;
  } res_t;
  res_t res_d, res_q;
  logic [31:0] rot_base, rot;
  always_comb begin
    rot_base = {24'd0, Instr[7:0]};
    rot = 32'({rot_base, rot_base} >> {Instr[11:8], 1'b0});
    res_d.side.mem_sel = (ImmSrc == MEM_OFS || ImmSrc == MEM_OFS_S) ? Instr[1:0] : WORD;
    res_d.side.rot_carry = ImmSrc == ROT_IMM && Instr[11:8] != 4'd0 && rot[31];
    res_d.side.illegal = ImmSrc > MEM_OFS_S;
    res_d.ext_imm = ImmSrc == IMM12_Z ? DATA_W'(Instr[11:0]) :
                    ImmSrc == MEM_OFS ? ((Instr[1:0] == BYTE || Instr[1:0] == HALF) ?
                                         DATA_W'(Instr[11:2]) : DATA_W'(Instr[11:0])) :
                    ImmSrc == BRANCH ? {{(DATA_W-26){Instr[23]}}, Instr[23:0], 2'b00} :
                    ImmSrc == ROT_IMM ? DATA_W'(rot) :
                    ImmSrc == MEM_OFS_S ? {{(DATA_W-12){Instr[11]}}, Instr[11:0]} : '0;
  end
  extend_skid_fifo #(.T(res_t)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din(res_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(res_q)
  );
  assign ExtImm = res_q.ext_imm;
  assign MemorySelector = res_q.side.mem_sel;
  assign RotCarry = res_q.side.rot_carry;
  assign Illegal = res_q.side.illegal;
endmodule

// File: tb/tb_extend_pipe.sv
// tb_extend_pipe: directed self-checking bench for extend_pipe
module tb_extend_pipe;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, RotCarry, Illegal;
  logic [23:0] Instr;
  logic [2:0] ImmSrc;
  logic [31:0] ExtImm;
  logic [1:0] MemorySelector;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  extend_pipe #(.DATA_W(32), .INSTR_W(24)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Instr(Instr),
    .ImmSrc(ImmSrc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ExtImm(ExtImm),
    .MemorySelector(MemorySelector),
    .RotCarry(RotCarry),
    .Illegal(Illegal)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [2:0] src, input logic [23:0] ins);
    in_valid = 1'b1;
    ImmSrc = src;
    Instr = ins;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic result(input string tag, input logic [31:0] imm, input logic [1:0] ms,
                        input logic rc, input logic ill);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_imm"}, 64'(ExtImm), 64'(imm));
    check({tag, "_ms"}, 64'(MemorySelector), 64'(ms));
    check({tag, "_rc"}, 64'(RotCarry), 64'(rc));
    check({tag, "_ill"}, 64'(Illegal), 64'(ill));
  endtask
  initial begin
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Instr = '0;
    ImmSrc = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(ExtImm), 64'd0);
    check("rst_ms", 64'(MemorySelector), 64'd0);
    check("rst_rc", 64'(RotCarry), 64'd0);
    check("rst_ill", 64'(Illegal), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1 check("ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);
    beat(3'b011, 24'h0001FF); result("rot", 32'hC000003F, 2'b00, 1'b1, 1'b0);
    beat(3'b011, 24'h000080); result("rot0", 32'h00000080, 2'b00, 1'b0, 1'b0);
    beat(3'b010, 24'hFFFFFE); result("br", 32'hFFFFFFF8, 2'b00, 1'b0, 1'b0);
    beat(3'b010, 24'h000001); result("brp", 32'h00000004, 2'b00, 1'b0, 1'b0);
    beat(3'b001, 24'h000105); result("mem", 32'h00000041, 2'b01, 1'b0, 1'b0);
    beat(3'b001, 24'h000FFF); result("mem11", 32'h00000FFF, 2'b11, 1'b0, 1'b0);
    beat(3'b100, 24'h000FFF); result("mems", 32'hFFFFFFFF, 2'b11, 1'b0, 1'b0);
    beat(3'b000, 24'hABC123); result("imm12", 32'h00000123, 2'b00, 1'b0, 1'b0);
    beat(3'b101, 24'hFFFFFF); result("ill5", 32'h0, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check("drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    ImmSrc = 3'b000;
    Instr = 24'h000111;
    @(negedge clk);
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a", 64'(ExtImm), 64'h111);
    Instr = 24'h000222;
    #1 check("bp_ready1", 64'(in_ready), 64'd1);
    @(negedge clk);
    Instr = 24'h000333;
    #1 check("bp_ready_full", 64'(in_ready), 64'd0);
    check("bp_a_hold", 64'(ExtImm), 64'h111);
    @(negedge clk);
    check("bp_a_hold2", 64'(ExtImm), 64'h111);
    check("bp_ready_full2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check("bp_ready_pop", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_b", 64'(ExtImm), 64'h222);
    @(negedge clk);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    check("bp_c", 64'(ExtImm), 64'h333);
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    Instr = 24'h000444;
    @(negedge clk);
    Instr = 24'h000555;
    @(negedge clk);
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    Instr = 24'h000666;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("fl_dropped", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    ImmSrc = 3'b011;
    Instr = 24'h0001FF;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_pre", 64'(RotCarry), 64'd1);
    reset = 1'b0;
    in_valid = 1'b1;
    #1 check("mr_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_imm", 64'(ExtImm), 64'd0);
    check("mr_rc", 64'(RotCarry), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mr_post_valid", 64'(out_valid), 64'd0);
    beat(3'b110, 24'hFFFFFF); result("ill6", 32'h0, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
